ws2812b_frame_scheduler: RTL

- Arbitrates LED-frame requests from NREQ sources (for example a bar display and a test pattern) onto one WS2812B strip.
- Streams the winning frame as per-pixel 24-bit GRB words to the downstream bit serialiser over a valid/ready handshake.
- Waits for the serialiser to drain, then enforces the strip latch/reset gap before accepting the next frame.
- Sits between the frame sources and the 50 MHz bit-timing serialiser.

---
 rtl/ws2812b_frame_scheduler.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ws2812b_frame_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ws2812b_frame_scheduler
// Purpose  : Round-robin arbiter and pixel streamer for one WS2812B strip.
//            Grants one of NREQ frame requesters, captures its LED on-mask and
//            GRB colour, streams N 24-bit pixel words (LED N-1 first, LED 0
//            last) over a valid/ready handshake, waits for the bit serialiser
//            to go idle and then holds the strip latch gap for RESET_CYCLES
//            clocks before the next frame may be granted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_50        in   1         50 MHz clock
//   rst           in   1         asynchronous reset, active low
//   req_valid     in   NREQ      per-requester frame request (held until ack)
//   req_mask      in   NREQ*N    per-requester LED on-mask, slice [i*N +: N]
//   req_colour    in   NREQ*24   per-requester GRB colour, slice [i*24 +: 24]
//   req_ack       out  NREQ      one-cycle capture acknowledge
//   grant_id      out  GW        current / last granted requester
//   pix_data      out  24        GRB word for the presented pixel
//   pix_valid     out  1         pix_data valid
//   pix_last      out  1         presented pixel is LED 0 (end of frame)
//   pix_ready     in   1         serialiser accepts the pixel
//   ser_idle      in   1         serialiser finished shifting all bits
//   latch_active  out  1         latch/reset gap in progress
//   frame_done    out  1         one-cycle pulse after the latch gap
//   busy          out  1         scheduler not idle
// ============================================================================
module ws2812b_frame_scheduler #(
    parameter int N            = 32,
    parameter int NREQ         = 2,
    parameter int RESET_CYCLES = 2750
) (
    input  logic                                   clk_50,
    input  logic                                   rst,
    input  logic [NREQ-1:0]                        req_valid,
    input  logic [NREQ*N-1:0]                      req_mask,
    input  logic [NREQ*24-1:0]                     req_colour,
    output logic [NREQ-1:0]                        req_ack,
    output logic [$clog2(NREQ > 1 ? NREQ : 2)-1:0] grant_id,
    output logic [23:0]                            pix_data,
    output logic                                   pix_valid,
    output logic                                   pix_last,
    input  logic                                   pix_ready,
    input  logic                                   ser_idle,
    output logic                                   latch_active,
    output logic                                   frame_done,
    output logic                                   busy
);

    // Widths: grant index, pixel index and latch-gap counter.
    localparam int c_grant_w = $clog2(NREQ > 1 ? NREQ : 2);
    localparam int c_idx_w   = $clog2(N > 1 ? N : 2);
    localparam int c_cnt_w   = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_LATCH  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_grant_w-1:0] r_grant;       // requester owning the current frame
    logic [c_grant_w-1:0] r_last_grant;  // round-robin pointer
    logic [c_idx_w-1:0]   r_idx;         // LED index being presented
    logic [N-1:0]         r_mask;        // frozen copy of the winner's mask
    logic [23:0]          r_colour;      // frozen copy of the winner's colour
    logic [c_cnt_w-1:0]   r_gap_cnt;     // latch-gap cycles already spent
    logic [NREQ-1:0]      r_ack;
    logic                 r_frame_done;

    logic                 w_win_found;
    logic [c_grant_w-1:0] w_win_id;
    logic [N-1:0]         w_win_mask;
    logic [23:0]          w_win_colour;

    logic                 w_grant_load;
    logic                 w_pix_adv;
    logic                 w_gap_clr;
    logic                 w_gap_inc;
    logic                 w_frame_end;
    logic                 w_idx_zero;
    logic                 w_gap_end;
    logic                 w_pix_on;

    // ------------------------------------------------------------------------
    // Round-robin winner search. Priority starts just above the last grant and
    // wraps: first scan the requesters numbered above the pointer, then the
    // ones at or below it. The reset value of the pointer (NREQ-1) makes
    // requester 0 the first in line.
    // ------------------------------------------------------------------------
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int c = 0; c < NREQ; c++) begin
            if (!w_win_found && req_valid[c] && (c > int'(r_last_grant))) begin
                w_win_found = 1'b1;
                w_win_id    = c_grant_w'(c);
            end
        end
        for (int c = 0; c < NREQ; c++) begin
            if (!w_win_found && req_valid[c] && (c <= int'(r_last_grant))) begin
                w_win_found = 1'b1;
                w_win_id    = c_grant_w'(c);
            end
        end
    end

    // Select the winner's mask and colour slices for capture.
    always_comb begin
        w_win_mask   = '0;
        w_win_colour = '0;
        for (int c = 0; c < NREQ; c++) begin
            if (w_win_id == c_grant_w'(c)) begin
                w_win_mask   = req_mask[c*N +: N];
                w_win_colour = req_colour[c*24 +: 24];
            end
        end
    end

    assign w_idx_zero = (r_idx == '0);
    assign w_gap_end  = (r_gap_cnt == c_cnt_w'(RESET_CYCLES - 1));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath control. Requests are only looked at in IDLE;
    // the handshake in STREAM is pix_valid & pix_ready, and pix_valid is
    // exactly "state is STREAM".
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_load = 1'b0;
        w_pix_adv    = 1'b0;
        w_gap_clr    = 1'b0;
        w_gap_inc    = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt  = ST_STREAM;
                    w_grant_load = 1'b1;
                end
            end
            ST_STREAM: begin
                if (pix_ready) begin
                    if (w_idx_zero) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_pix_adv = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (ser_idle) begin
                    w_state_nxt = ST_LATCH;
                    w_gap_clr   = 1'b1;
                end
            end
            ST_LATCH: begin
                // The counter stops at RESET_CYCLES-1: that is the last gap
                // cycle, so it never needs to wrap.
                if (w_gap_end) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end else begin
                    w_gap_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            r_grant      <= '0;
            r_last_grant <= c_grant_w'(NREQ - 1);
            r_idx        <= '0;
            r_mask       <= '0;
            r_colour     <= '0;
            r_gap_cnt    <= '0;
            r_ack        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // Ack and frame_done are single-cycle pulses by construction: the
            // ack is only set on the IDLE->STREAM edge, frame_done only on
            // the LATCH->IDLE edge.
            r_ack        <= '0;
            r_frame_done <= w_frame_end;

            if (w_grant_load) begin
                r_grant  <= w_win_id;
                r_mask   <= w_win_mask;
                r_colour <= w_win_colour;
                r_idx    <= c_idx_w'(N - 1);
                r_ack    <= NREQ'(1) << w_win_id;
            end

            if (w_pix_adv) begin
                r_idx <= r_idx - c_idx_w'(1);
            end

            if (w_gap_clr) begin
                r_gap_cnt <= '0;
            end else if (w_gap_inc) begin
                r_gap_cnt <= r_gap_cnt + c_cnt_w'(1);
            end

            // The pointer moves only once a frame has fully completed, so a
            // frame abandoned by reset does not cost its owner a turn.
            if (w_frame_end) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded from registers, none from inputs.
    // ------------------------------------------------------------------------
    assign w_pix_on     = |(r_mask & (N'(1) << r_idx));

    assign pix_valid    = (r_state == ST_STREAM);
    assign pix_last     = pix_valid && w_idx_zero;
    assign pix_data     = (pix_valid && w_pix_on) ? r_colour : 24'h000000;
    assign latch_active = (r_state == ST_LATCH);
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;
    assign req_ack      = r_ack;
    assign grant_id     = r_grant;

endmodule
`default_nettype wire
